spike_aer_encoder: RTL and testbench

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder_pkg.sv | 18 +
 rtl/spike_aer_encoder_fifo.sv | 69 ++++++
 rtl/spike_aer_encoder.sv | 129 ++++++++++++
 tb/tb_spike_aer_encoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and constants for the spike-to-AER encoder.
package lif_aer_pkg;

    localparam int DROP_CNT_W     = 16;
    localparam int AER_ADDR_MAX_W = 10;
    localparam int AER_TS_MAX_W   = 32;

    // Widest event record; instances carry only ADDR_W (+ TS_WIDTH) of it.
    typedef struct packed {
        logic [AER_TS_MAX_W-1:0]   ts;
        logic [AER_ADDR_MAX_W-1:0] addr;
    } aer_event_t;

    function automatic int addr_w(input int num_neurons);
        return (num_neurons < 2) ? 1 : $clog2(num_neurons);
    endfunction

endpackage

// File: rtl/spike_aer_encoder_fifo.sv
// Event FIFO with registered output; occupancy includes the word held at the output.
module aer_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, remain;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dout_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & valid_q;
    // A pop frees the slot on the same edge, so a full FIFO still takes a push.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        remain   = count_q - CNT_W'(do_pop);
        count_d  = remain + CNT_W'(do_push);
        valid_d  = (remain != '0);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    // Only entries written before this edge are read, giving a two-edge push-to-valid path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            if (valid_d) begin
                dout_q <= mem[rd_ptr_d];
            end
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = dout_q;

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: rising-edge detect, lowest-index arbiter, event FIFO.
// Define LIF_AER_TIMESTAMP_EN to add the timestamp counter and the aer_ts port.
module spike_aer_encoder
    import lif_aer_pkg::*;
#(
    parameter int  NUM_NEURONS = 16,
    parameter int  FIFO_DEPTH  = 8,
    parameter int  TS_WIDTH    = 16,
    localparam int ADDR_W      = addr_w(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spike,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ADDR_W-1:0]      aer_addr,
`ifdef LIF_AER_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0]    aer_ts,
`endif
    output logic [DROP_CNT_W-1:0]  drop_cnt,
    output logic                   overflow
);
`ifdef LIF_AER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int EV_W   = ADDR_W + (TS_EN ? TS_WIDTH : 0);
    localparam int LOST_W = $clog2(NUM_NEURONS + 1);

    logic [NUM_NEURONS-1:0] spike_q, pending_q, pending_d;
    logic [NUM_NEURONS-1:0] rise, grant_vec, lost;
    logic [NUM_NEURONS:0]   any_below;
    logic [ADDR_W-1:0]      grant_addr;
    logic [LOST_W-1:0]      lost_cnt;
    logic [DROP_CNT_W:0]    drop_sum;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_full, fifo_empty, fifo_pop, can_grant, push;
    logic [EV_W-1:0]        push_ev, head_ev;

    assign rise      = spike & ~spike_q;
    assign fifo_pop  = aer_valid & aer_ready & ~fifo_empty;
    assign can_grant = ~fifo_full | fifo_pop;

    // Priority chain: a neuron wins only if no lower index is pending.
    genvar gi;
    assign any_below[0] = 1'b0;
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_arb
        assign any_below[gi+1] = any_below[gi] | pending_q[gi];
        assign grant_vec[gi]   = can_grant & pending_q[gi] & ~any_below[gi];
    end
    assign push = can_grant & any_below[NUM_NEURONS];

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (grant_vec[i]) begin
                grant_addr = ADDR_W'(i);
            end
        end
    end

    // A new edge on a still-pending neuron merges into the existing request.
    assign lost      = rise & pending_q & ~grant_vec;
    assign pending_d = (pending_q & ~grant_vec) | rise;

    always_comb begin
        lost_cnt = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            lost_cnt = lost_cnt + LOST_W'(lost[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(lost_cnt);
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        overflow_d = overflow_q | (|lost);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_q    <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            spike_q    <= spike;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef LIF_AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    assign push_ev  = {ts_q, grant_addr};
    assign aer_addr = head_ev[ADDR_W-1:0];
    assign aer_ts   = head_ev[EV_W-1:ADDR_W];
`else
    assign push_ev  = grant_addr;
    assign aer_addr = head_ev;
`endif

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .din_i   (push_ev),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .valid_o (aer_valid),
        .dout_o  (head_ev)
    );

    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed self-checking bench for spike_aer_encoder (timestamp checks need LIF_AER_TIMESTAMP_EN).
module tb_spike_aer_encoder;
    localparam int N   = 16;
    localparam int D   = 8;
    localparam int TSW = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  spike;
    logic          aer_valid;
    logic          aer_ready;
    logic [AW-1:0] aer_addr;
`ifdef LIF_AER_TIMESTAMP_EN
    logic [TSW-1:0] aer_ts;
`endif
    logic [15:0]   drop_cnt;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_addr[$];
    int ev_ts[$];
    int ev_cyc[$];

    always #5 clk = ~clk;

    spike_aer_encoder #(
        .NUM_NEURONS (N),
        .FIFO_DEPTH  (D),
        .TS_WIDTH    (TSW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spike     (spike),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
`ifdef LIF_AER_TIMESTAMP_EN
        .aer_ts    (aer_ts),
`endif
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        spike     = '0;
        aer_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Samples at the negedge; a transfer happens on the following posedge.
    task automatic collect(input int cycles);
        int ts_now;
        ev_addr.delete();
        ev_ts.delete();
        ev_cyc.delete();
        for (int c = 0; c < cycles; c++) begin
            if (aer_valid && aer_ready) begin
`ifdef LIF_AER_TIMESTAMP_EN
                ts_now = int'(aer_ts);
`else
                ts_now = 0;
`endif
                ev_addr.push_back(int'(aer_addr));
                ev_ts.push_back(ts_now);
                ev_cyc.push_back(c);
                $display("event cyc=%0d addr=%0d ts=%0d", c, aer_addr, ts_now);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        spike     = '0;
        aer_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (aer_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", aer_valid); end
        n_cmp++; if (aer_addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", aer_addr); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        rst = 1'b1;
    endtask

    task automatic test_single_spike();
        do_reset();
        aer_ready = 1'b1;
        spike[5] = 1'b1;
        tick();
        n_cmp++; if (aer_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1: got %0b want 0", aer_valid); end
        tick();
        n_cmp++; if (aer_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat2: got %0b want 0", aer_valid); end
        tick();
        n_cmp++; if (aer_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat3: got %0b want 1", aer_valid); end
        n_cmp++; if (aer_addr !== 4'd5) begin n_bad++; $display("FAIL single_addr: got %0d want 5", aer_addr); end
        collect(10);
        spike = '0;
        n_cmp++; if (ev_addr.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", ev_addr.size()); end
        else if (ev_addr[0] != 5) begin n_bad++; $display("FAIL single_ev_addr: got %0d want 5", ev_addr[0]); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL single_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        aer_ready = 1'b1;
        spike = 16'h0089;
        collect(10);
        spike = '0;
        n_cmp++;
        if (ev_addr.size() != 3) begin
            n_bad++; $display("FAIL simul_count: got %0d want 3", ev_addr.size());
        end else begin
            n_cmp++; if (ev_addr[0] != 0) begin n_bad++; $display("FAIL simul_addr0: got %0d want 0", ev_addr[0]); end
            n_cmp++; if (ev_addr[1] != 3) begin n_bad++; $display("FAIL simul_addr1: got %0d want 3", ev_addr[1]); end
            n_cmp++; if (ev_addr[2] != 7) begin n_bad++; $display("FAIL simul_addr2: got %0d want 7", ev_addr[2]); end
            n_cmp++; if (ev_cyc[2] - ev_cyc[0] != 2) begin n_bad++; $display("FAIL simul_spacing: got %0d want 2", ev_cyc[2] - ev_cyc[0]); end
`ifdef LIF_AER_TIMESTAMP_EN
            n_cmp++; if (((ev_ts[1] - ev_ts[0]) & 15) != 1) begin n_bad++; $display("FAIL simul_ts01: got %0d want 1", (ev_ts[1] - ev_ts[0]) & 15); end
            n_cmp++; if (((ev_ts[2] - ev_ts[1]) & 15) != 1) begin n_bad++; $display("FAIL simul_ts12: got %0d want 1", (ev_ts[2] - ev_ts[1]) & 15); end
`endif
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        spike = 16'h03FF;
        repeat (14) tick();
        n_cmp++; if (aer_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %0b want 1", aer_valid); end
        n_cmp++; if (aer_addr !== 4'd0) begin n_bad++; $display("FAIL bp_head: got %0d want 0", aer_addr); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL bp_drop: got %0d want 0", drop_cnt); end
        repeat (3) tick();
        n_cmp++; if (aer_addr !== 4'd0) begin n_bad++; $display("FAIL bp_stable: got %0d want 0", aer_addr); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_ovf: got %0b want 0", overflow); end
        aer_ready = 1'b1;
        collect(20);
        spike = '0;
        n_cmp++;
        if (ev_addr.size() != 10) begin
            n_bad++; $display("FAIL bp_count: got %0d want 10", ev_addr.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++; if (ev_addr[i] != i) begin n_bad++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, ev_addr[i], i); end
            end
            n_cmp++; if (ev_cyc[9] - ev_cyc[0] != 9) begin n_bad++; $display("FAIL bp_throughput: got %0d want 9", ev_cyc[9] - ev_cyc[0]); end
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        spike = 16'hFF00;
        repeat (14) tick();
        spike = '0;
        tick();
        tick();
        spike = 16'h0004;
        tick();
        spike = '0;
        tick();
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL coal_drop_first: got %0d want 0", drop_cnt); end
        spike = 16'h0004;
        tick();
        spike = '0;
        tick();
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL coal_drop: got %0d want 1", drop_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL coal_ovf: got %0b want 1", overflow); end
        aer_ready = 1'b1;
        collect(20);
        n_cmp++;
        if (ev_addr.size() != 9) begin
            n_bad++; $display("FAIL coal_count: got %0d want 9", ev_addr.size());
        end else begin
            n_cmp++; if (ev_addr[0] != 8) begin n_bad++; $display("FAIL coal_first: got %0d want 8", ev_addr[0]); end
            n_cmp++; if (ev_addr[8] != 2) begin n_bad++; $display("FAIL coal_last: got %0d want 2", ev_addr[8]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        spike = 16'h000F;
        repeat (8) tick();
        n_cmp++; if (aer_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid: got %0b want 1", aer_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (aer_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_async_valid: got %0b want 0", aer_valid); end
        n_cmp++; if (aer_addr !== 4'd0) begin n_bad++; $display("FAIL rmid_async_addr: got %0d want 0", aer_addr); end
        spike = '0;
        tick();
        tick();
        rst = 1'b1;
        aer_ready = 1'b1;
        collect(12);
        n_cmp++; if (ev_addr.size() != 0) begin n_bad++; $display("FAIL rmid_stale: got %0d events want 0", ev_addr.size()); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0;
        spike = 16'h0040;
        tick();
        tick();
        rst = 1'b1;
        collect(10);
        spike = '0;
        n_cmp++;
        if (ev_addr.size() != 1) begin
            n_bad++; $display("FAIL rmid_held_count: got %0d want 1", ev_addr.size());
        end else if (ev_addr[0] != 6) begin
            n_bad++; $display("FAIL rmid_held_addr: got %0d want 6", ev_addr[0]);
        end
    endtask

`ifdef LIF_AER_TIMESTAMP_EN
    task automatic test_ts_wrap();
        do_reset();
        aer_ready = 1'b1;
        repeat (16) tick();
        spike = 16'h0002;
        collect(8);
        spike = '0;
        n_cmp++;
        if (ev_addr.size() != 1) begin
            n_bad++; $display("FAIL wrap_count: got %0d want 1", ev_addr.size());
        end else begin
            n_cmp++; if (ev_ts[0] != 1) begin n_bad++; $display("FAIL wrap_ts: got %0d want 1", ev_ts[0]); end
            n_cmp++; if (ev_addr[0] != 1) begin n_bad++; $display("FAIL wrap_addr: got %0d want 1", ev_addr[0]); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_spike();
        test_simultaneous();
        test_backpressure();
        test_coalesce();
        test_reset_mid();
`ifdef LIF_AER_TIMESTAMP_EN
        test_ts_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
